mealy_run_detector: RTL and testbench

//   Multi-channel, parametrised Mealy run detector. It is the generalised successor of the

---
 rtl/mealy_run_detector_pkg.sv | 29 ++
 rtl/mealy_run_detector_if.sv | 38 +++
 rtl/mealy_run_detector_chan.sv | 117 +++++++++++
 rtl/mealy_run_detector.sv | 60 ++++++
 tb/tb_mealy_run_detector.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mealy_run_detector_pkg.sv
// ----------------------------------------------------------------------------
// Package: mealy_run_pkg
// Purpose : Shared types and constants for the multi-channel Mealy run
//           detector. It holds the per-channel state record and the helper
//           that sizes a run-length counter for a given minimum run length.
// Contents:
//   cnt_w(run_len)  bits needed to count from 0 up to run_len inclusive
//   RUN_LEN_MAX     largest legal minimum run length
//   CNT_MAX_W       counter width that covers every legal run length
//   chan_st_t       {vld, last, cnt} state of one channel
// ----------------------------------------------------------------------------
package mealy_run_pkg;

    function automatic int cnt_w(input int run_len);
        return $clog2(run_len + 1);
    endfunction

    localparam int RUN_LEN_MAX = 255;
    localparam int CNT_MAX_W   = cnt_w(RUN_LEN_MAX);

    // The counter field is sized for the largest legal run length so that one
    // packed type serves every parameterisation; it never counts past RUN_LEN.
    typedef struct packed {
        logic                 vld;
        logic                 last;
        logic [CNT_MAX_W-1:0] cnt;
    } chan_st_t;

endpackage

// File: rtl/mealy_run_detector_if.sv
// ----------------------------------------------------------------------------
// Interface: mealy_run_detector_if
// Purpose  : Bundles the per-channel data, enable, clear and result signals
//            of the run detector.
// Signals (all NCH wide unless noted):
//   din      serial data bit per channel
//   cen      per-channel enable
//   ev_clr   per-channel clear of the terminated-run counter
//   doutx    qualifying run terminated this cycle
//   douty    run reaches or extends at/past the qualifying length
//   run_bit  value of the run currently tracked
//   ev_cnt   NCH*EV_W packed event counters, channel c at [c*EV_W +: EV_W]
// Modports: master drives din/cen/ev_clr, slave (the detector) drives results.
// ----------------------------------------------------------------------------
interface mealy_run_detector_if
    import mealy_run_pkg::*;
#(
    parameter int NCH  = 1,
    parameter int EV_W = 8
);
    logic [NCH-1:0]      din;
    logic [NCH-1:0]      cen;
    logic [NCH-1:0]      ev_clr;
    logic [NCH-1:0]      doutx;
    logic [NCH-1:0]      douty;
    logic [NCH-1:0]      run_bit;
    logic [NCH*EV_W-1:0] ev_cnt;

    modport master (
        output din, cen, ev_clr,
        input  doutx, douty, run_bit, ev_cnt
    );

    modport slave (
        input  din, cen, ev_clr,
        output doutx, douty, run_bit, ev_cnt
    );
endinterface

// File: rtl/mealy_run_detector_chan.sv
// ----------------------------------------------------------------------------
// Module : mealy_run_chan
// Purpose: One channel of the run detector: run-length tracking state,
//          Mealy outputs and the saturating terminated-run counter.
// Ports  :
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   din      serial data bit
//   cen      enable; gates state update and the run outputs
//   ev_clr   synchronous clear of ev_cnt (wins over a coincident increment)
//   doutx    qualifying run terminated this cycle
//   douty    run reaches or extends at/past RUN_LEN this cycle
//   run_bit  last registered bit of the tracked run
//   ev_cnt   saturating count of doutx pulses
// Config : MEALY_RUN_REG_OUT_EN registers doutx/douty one cycle later.
// ----------------------------------------------------------------------------
module mealy_run_chan
    import mealy_run_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int EV_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din,
    input  logic            cen,
    input  logic            ev_clr,
    output logic            doutx,
    output logic            douty,
    output logic            run_bit,
    output logic [EV_W-1:0] ev_cnt
);

    localparam logic [CNT_MAX_W-1:0] RUN_LEN_CNT = CNT_MAX_W'(RUN_LEN);
    localparam logic [CNT_MAX_W:0]   RUN_LEN_EXT = (CNT_MAX_W + 1)'(RUN_LEN);
    localparam logic [CNT_MAX_W-1:0] CNT_ONE     = CNT_MAX_W'(1);
    localparam logic [EV_W-1:0]      EV_ONE      = EV_W'(1);

    chan_st_t             st_q;
    logic [EV_W-1:0]      ev_q;
    logic                 same_bit;
    logic [CNT_MAX_W:0]   cnt_inc;
    logic                 term_hit;
    logic                 ext_hit;

    // Run outputs are decided from the held state and the bit arriving now.
    // The increment is one bit wider than the counter so the comparison
    // against RUN_LEN can never see a wrapped value.
    always_comb begin
        same_bit = (din == st_q.last);
        cnt_inc  = {1'b0, st_q.cnt} + {{CNT_MAX_W{1'b0}}, 1'b1};
        term_hit = cen & st_q.vld & ~same_bit & (st_q.cnt == RUN_LEN_CNT);
        ext_hit  = cen & st_q.vld & same_bit & (cnt_inc >= RUN_LEN_EXT);
    end

    // Run tracking: the first enabled bit only opens a run, a repeated bit
    // lengthens it (saturating at RUN_LEN), a different bit starts a new run.
    // Disabled cycles leave the run untouched so idle gaps do not break it.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= '0;
        end else if (cen) begin
            if (!st_q.vld) begin
                st_q.vld  <= 1'b1;
                st_q.last <= din;
                st_q.cnt  <= CNT_ONE;
            end else if (same_bit) begin
                if (st_q.cnt < RUN_LEN_CNT) begin
                    st_q.cnt <= cnt_inc[CNT_MAX_W-1:0];
                end
            end else begin
                st_q.last <= din;
                st_q.cnt  <= CNT_ONE;
            end
        end
    end

    // Terminated-run counter: sticks at all-ones, and a clear beats a
    // termination arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q <= '0;
        end else if (ev_clr) begin
            ev_q <= '0;
        end else if (term_hit && (ev_q != '1)) begin
            ev_q <= ev_q + EV_ONE;
        end
    end

`ifdef MEALY_RUN_REG_OUT_EN
    logic doutx_q;
    logic douty_q;

    // Registered variant: the run outputs trail their cause by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            doutx_q <= 1'b0;
            douty_q <= 1'b0;
        end else begin
            doutx_q <= term_hit;
            douty_q <= ext_hit;
        end
    end

    assign doutx = ~reset & doutx_q;
    assign douty = ~reset & douty_q;
`else
    assign doutx = ~reset & term_hit;
    assign douty = ~reset & ext_hit;
`endif

    // Everything visible reads as zero while reset is asserted, even before
    // the reset edge has cleared the registers.
    assign run_bit = ~reset & st_q.last;
    assign ev_cnt  = reset ? '0 : ev_q;

endmodule

// File: rtl/mealy_run_detector.sv
// ----------------------------------------------------------------------------
// Module : mealy_run_detector
// Purpose: Multi-channel Mealy run detector. Each channel independently
//          tracks its current run of identical bits, flags qualifying runs
//          that extend or terminate, and counts terminations.
// Ports  :
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mealy_run_detector_if.slave: din, cen, ev_clr in;
//          doutx, douty, run_bit, ev_cnt (NCH*EV_W packed) out
// Params : NCH channels, RUN_LEN minimum qualifying length (1..255),
//          EV_W event counter width.
// Config : MEALY_RUN_REG_OUT_EN registers doutx/douty (1-cycle later).
// ----------------------------------------------------------------------------
module mealy_run_detector
    import mealy_run_pkg::*;
#(
    parameter int NCH     = 1,
    parameter int RUN_LEN = 2,
    parameter int EV_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mealy_run_detector_if.slave bus
);

    // Reject run lengths the counter type cannot represent.
    if ((RUN_LEN < 1) || (RUN_LEN > RUN_LEN_MAX)) begin : g_bad_run_len
        $error("mealy_run_detector: RUN_LEN must be within 1..RUN_LEN_MAX");
    end

    logic [NCH-1:0]      doutx_v;
    logic [NCH-1:0]      douty_v;
    logic [NCH-1:0]      run_bit_v;
    logic [NCH*EV_W-1:0] ev_cnt_v;

    // Channels share nothing but the clock and reset.
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        mealy_run_chan #(
            .RUN_LEN (RUN_LEN),
            .EV_W    (EV_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .din     (bus.din[c]),
            .cen     (bus.cen[c]),
            .ev_clr  (bus.ev_clr[c]),
            .doutx   (doutx_v[c]),
            .douty   (douty_v[c]),
            .run_bit (run_bit_v[c]),
            .ev_cnt  (ev_cnt_v[c*EV_W +: EV_W])
        );
    end

    assign bus.doutx   = doutx_v;
    assign bus.douty   = douty_v;
    assign bus.run_bit = run_bit_v;
    assign bus.ev_cnt  = ev_cnt_v;

endmodule

// File: tb/tb_mealy_run_detector.sv
// ----------------------------------------------------------------------------
// Testbench: tb_mealy_run_detector
// Purpose  : Directed stimulus for a 2-channel, RUN_LEN=2, EV_W=4 detector.
//            A run-length model (unbounded integer run lengths) predicts
//            every output on every cycle; literal expectations pin the model.
// Config   : honours MEALY_RUN_REG_OUT_EN for the registered-output build.
// ----------------------------------------------------------------------------
module tb_mealy_run_detector;

    localparam int NCH     = 2;
    localparam int RUN_LEN = 2;
    localparam int EV_W    = 4;
    localparam int EV_MAX  = (1 << EV_W) - 1;

`ifdef MEALY_RUN_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    mealy_run_detector_if #(.NCH(NCH), .EV_W(EV_W)) bus_if ();

    mealy_run_detector #(
        .NCH     (NCH),
        .RUN_LEN (RUN_LEN),
        .EV_W    (EV_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, whether a run is open, its bit value,
    // its true length, the terminated-run count and the last cycle's
    // run outputs (for the registered build).
    bit m_vld  [NCH];
    bit m_last [NCH];
    int m_run  [NCH];
    int m_ev   [NCH];
    bit m_px   [NCH];
    bit m_py   [NCH];

    function automatic bit model_x(int c);
        return !reset && bus_if.cen[c] && m_vld[c] &&
               (bus_if.din[c] != m_last[c]) && (m_run[c] >= RUN_LEN);
    endfunction

    function automatic bit model_y(int c);
        return !reset && bus_if.cen[c] && m_vld[c] &&
               (bus_if.din[c] == m_last[c]) && (m_run[c] + 1 >= RUN_LEN);
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_vld[c] = 0; m_last[c] = 0; m_run[c] = 0; m_ev[c] = 0;
                m_px[c]  = 0; m_py[c]   = 0;
            end else begin
                m_px[c] = model_x(c);
                m_py[c] = model_y(c);
                if (bus_if.ev_clr[c])
                    m_ev[c] = 0;
                else if (m_px[c] && m_ev[c] < EV_MAX)
                    m_ev[c] = m_ev[c] + 1;
                if (bus_if.cen[c]) begin
                    if (!m_vld[c]) begin
                        m_vld[c] = 1; m_last[c] = bus_if.din[c]; m_run[c] = 1;
                    end else if (bus_if.din[c] == m_last[c]) begin
                        m_run[c] = m_run[c] + 1;
                    end else begin
                        m_last[c] = bus_if.din[c]; m_run[c] = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                bit ex, ey;
                if (REG_OUT) begin
                    ex = !reset && m_px[c];
                    ey = !reset && m_py[c];
                end else begin
                    ex = model_x(c);
                    ey = model_y(c);
                end
                checkOutput($sformatf("model doutx ch%0d", c), int'(bus_if.doutx[c]), int'(ex));
                checkOutput($sformatf("model douty ch%0d", c), int'(bus_if.douty[c]), int'(ey));
                checkOutput($sformatf("model run_bit ch%0d", c), int'(bus_if.run_bit[c]),
                            reset ? 0 : int'(m_last[c]));
                checkOutput($sformatf("model ev_cnt ch%0d", c),
                            int'(bus_if.ev_cnt[c*EV_W +: EV_W]), reset ? 0 : m_ev[c]);
            end
        end
    end

    // One cycle: change inputs just after the rising edge, return at the
    // falling edge so the caller can inspect this cycle's outputs.
    task automatic applyStimulus(input logic [1:0] d, input logic [1:0] e,
                                 input logic [1:0] clr, input logic r);
        @(posedge clk);
        #1;
        bus_if.din    = d;
        bus_if.cen    = e;
        bus_if.ev_clr = clr;
        reset         = r;
        @(negedge clk);
    endtask

    int ev0;
    logic [4:0] exp_y1, exp_x1;
    logic [5:0] exp_y3;
    logic [1:0] exp_x4;

    initial begin
        bus_if.din    = '0;
        bus_if.cen    = '0;
        bus_if.ev_clr = '0;
        chk_en        = 1'b1;

        // Reset state, with inputs that would otherwise produce activity.
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b1);
        checkOutput("reset doutx", int'(bus_if.doutx), 0);
        checkOutput("reset douty", int'(bus_if.douty), 0);
        checkOutput("reset ev_cnt", int'(bus_if.ev_cnt), 0);

        // Test 1: ch0 1,1,1,0 then an idle cycle.
        exp_y1 = REG_OUT ? 5'b01100 : 5'b00110;
        exp_x1 = REG_OUT ? 5'b10000 : 5'b01000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i == 3) ? 2'b00 : 2'b01, (i == 4) ? 2'b00 : 2'b01, 2'b00, 1'b0);
            checkOutput($sformatf("t1 douty cyc%0d", i + 1), int'(bus_if.douty[0]), int'(exp_y1[i]));
            checkOutput($sformatf("t1 doutx cyc%0d", i + 1), int'(bus_if.doutx[0]), int'(exp_x1[i]));
        end
        checkOutput("t1 ev_cnt ch0", int'(bus_if.ev_cnt[EV_W-1:0]), 1);

        // Test 2: ch0 alternating after a reset.
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00, 2'b01, 2'b00, 1'b0);
            checkOutput($sformatf("t2 doutx cyc%0d", i + 1), int'(bus_if.doutx[0]), 0);
            checkOutput($sformatf("t2 douty cyc%0d", i + 1), int'(bus_if.douty[0]), 0);
        end
        checkOutput("t2 ev_cnt ch0", int'(bus_if.ev_cnt[EV_W-1:0]), 0);

        // Test 3: ch1 run survives an idle gap with a different din.
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
        exp_y3 = REG_OUT ? 6'b100000 : 6'b010000;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] d, e;
            d = (i >= 1 && i <= 3) ? 2'b10 : 2'b00;
            e = (i >= 1 && i <= 3 || i == 5) ? 2'b00 : 2'b10;
            applyStimulus(d, e, 2'b00, 1'b0);
            checkOutput($sformatf("t3 douty ch1 cyc%0d", i + 1), int'(bus_if.douty[1]), int'(exp_y3[i]));
            checkOutput($sformatf("t3 doutx ch1 cyc%0d", i + 1), int'(bus_if.doutx[1]), 0);
        end

        // Test 4: 18 pairs on ch0 give 17 terminations; ch1 holds a steady 1.
        for (int k = 0; k < 18; k++) begin
            logic v;
            v = (k % 2 == 0);
            applyStimulus({1'b1, v}, 2'b11, 2'b00, 1'b0);
            applyStimulus({1'b1, v}, 2'b11, 2'b00, 1'b0);
        end
        exp_x4 = REG_OUT ? 2'b10 : 2'b01;
        applyStimulus(2'b11, 2'b11, 2'b01, 1'b0);
        ev0 = int'(bus_if.ev_cnt[EV_W-1:0]);
        checkOutput("t4 ev_cnt saturated", ev0, 15);
        checkOutput("t4 doutx with clear", int'(bus_if.doutx[0]), int'(exp_x4[0]));
        applyStimulus(2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("t4 ev_cnt after clear", int'(bus_if.ev_cnt[EV_W-1:0]), 0);
        checkOutput("t4 doutx after clear", int'(bus_if.doutx[0]), int'(exp_x4[1]));

        // Test 5: reset in the middle of a run discards it.
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
        checkOutput("t5 run_bit before reset", int'(bus_if.run_bit[0]), 1);
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b1);
        checkOutput("t5 run_bit in reset", int'(bus_if.run_bit[0]), 0);
        applyStimulus(2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput("t5 doutx after reset", int'(bus_if.doutx[0]), 0);
        checkOutput("t5 douty after reset", int'(bus_if.douty[0]), 0);

        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
